// File: rtl/fetch_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer_pkg : shared types and constants for the fetch path |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_buffer.sv
// +--------------------------------------------------------------------+
// | fetch_buffer : one-entry instruction/PC holding register            |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_buffer
    import fetch_sequencer_pkg::*;
#(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [N-1:0]       pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [N-1:0]       pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [N-1:0]       pc_q;

    // Clearing drops only the valid flag; payload is don't-care once invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer : PC ownership and req/gnt/rvalid instruction fetch |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int         N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [N-1:0]       PCBranch_F,
    input  logic               stall_D,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [N-1:0]       pc_D,
    output logic               outstanding
);

    state_e             state_q, state_d;
    logic [N-1:0]       pc_q, pc_d, inflight_pc_q, inflight_pc_d, pc_plus4;
    logic               squash_q, squash_d;
    logic               redirect, grant, resp, resp_live, out_free;
    logic               out_load, out_clear, hold_load, hold_clear;
    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr, load_instr;
    logic [N-1:0]       hold_pc, load_pc;

    assign redirect  = PCSrc_F && (state_q != ST_BOOT);
    assign grant     = (state_q == ST_REQ) && imem_gnt;
    assign resp      = (state_q == ST_WAIT) && imem_rvalid;
    assign resp_live = resp && !squash_q && !redirect;
    assign out_free  = !stall_D || !instr_valid_D;
    assign pc_plus4  = pc_q + N'(PC_INC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ:  if (grant) state_d = ST_WAIT;
            ST_WAIT: if (resp) state_d = (resp_live && !out_free) ? ST_HOLD : ST_REQ;
            ST_HOLD: if (redirect || !stall_D) state_d = ST_REQ;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_REQ);
        outstanding = (state_q == ST_WAIT);
        hold_load   = resp_live && !out_free;
        hold_clear  = (state_q == ST_HOLD) && (redirect || !stall_D);
        out_load    = (resp_live && out_free) ||
                      ((state_q == ST_HOLD) && hold_valid && !redirect && !stall_D);
        out_clear   = redirect || (!stall_D && !out_load);
    end

    // A redirect racing a grant still issues the old PC, so its response must be squashed.
    always_comb begin
        pc_d          = redirect ? PCBranch_F : (grant ? pc_plus4 : pc_q);
        inflight_pc_d = grant ? pc_q : inflight_pc_q;
        squash_d      = squash_q;
        if (resp)
            squash_d = 1'b0;
        else if (redirect && (grant || state_q == ST_WAIT))
            squash_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
        end
    end

    assign imem_addr  = pc_q;
    assign load_instr = (state_q == ST_HOLD) ? hold_instr : imem_rdata;
    assign load_pc    = (state_q == ST_HOLD) ? hold_pc    : inflight_pc_q;

    fetch_buffer #(.N(N)) u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .instr_i (imem_rdata),
        .pc_i    (inflight_pc_q),
        .valid_o (hold_valid),
        .instr_o (hold_instr),
        .pc_o    (hold_pc)
    );

    fetch_buffer #(.N(N)) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (out_load),
        .clear_i (out_clear),
        .instr_i (load_instr),
        .pc_i    (load_pc),
        .valid_o (instr_valid_D),
        .instr_o (instr_D),
        .pc_o    (pc_D)
    );

endmodule

`default_nettype wire
